// File: rtl/dm_bridge_pkg.sv
// Shared definitions for the data-memory bridge:
//   - FSM state encoding
//   - load-type codes carried on ld_op
//   - default bus-ack timeout
//   - captured request payload and store-lane replication helper
package dm_bridge_pkg;

    localparam int unsigned TIMEOUT_DEF = 255;
    localparam int unsigned XLEN        = 32;
    localparam int unsigned NBYTES      = XLEN / 8;
    localparam int unsigned LDW         = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Load-type codes on ld_op
    localparam logic [LDW-1:0] LD_NONE = 3'b000;
    localparam logic [LDW-1:0] LD_W    = 3'b001;
    localparam logic [LDW-1:0] LD_B    = 3'b010;
    localparam logic [LDW-1:0] LD_BU   = 3'b011;
    localparam logic [LDW-1:0] LD_H    = 3'b100;
    localparam logic [LDW-1:0] LD_HU   = 3'b101;

    // Request captured in IDLE and replayed onto the bus for every REQ cycle
    typedef struct packed {
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   wdata;
        logic [NBYTES-1:0] byteen;
        logic              we;
        logic [LDW-1:0]    ld_op;
    } req_t;

    // Copy the low byte / half of the store source onto every lane it may hit
    function automatic logic [XLEN-1:0] replicate_wdata(input logic [NBYTES-1:0] be,
                                                        input logic [XLEN-1:0]   d);
        logic [XLEN-1:0] r;
        case ($countones(be))
            1:       r = {4{d[7:0]}};
            2:       r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dm_bridge_ld_ext.sv
// Load extender (combinational).
// Selects the addressed byte / half of a bus read word and sign- or
// zero-extends it according to the load type.
//   word    : raw 32-bit read word
//   addr_lo : byte offset within the word
//   ld_op   : load type code
//   rd_data : aligned, extended load result (0 for no load / unknown code)
module ld_ext
    import dm_bridge_pkg::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      addr_lo,
    input  logic [LDW-1:0]  ld_op,
    output logic [XLEN-1:0] rd_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        half_sel = 16'h0000;
        rd_data  = '0;

        case (addr_lo)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];

        case (ld_op)
            LD_W:    rd_data = word;
            LD_B:    rd_data = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   rd_data = {24'h000000, byte_sel};
            LD_H:    rd_data = {{16{half_sel[15]}}, half_sel};
            LD_HU:   rd_data = {16'h0000, half_sel};
            default: rd_data = '0;
        endcase
    end

endmodule

// File: rtl/dm_bridge.sv
// Data-memory bridge between the pipeline M stage and a simple req/ack bus.
// Captures one load or store, holds the pipeline while the bus request is
// outstanding, and returns an aligned load result for one cycle.
//   clk, reset          : clock, synchronous active-high reset
//   m_valid, byteen,
//   ld_op, addr, wdata  : memory instruction from the M stage
//   stall               : freeze pipeline up to and including M
//   rd_data, rd_valid   : load result, valid for one cycle per load
//   err                 : sticky bus-timeout flag
//   bus_req, bus_we,
//   bus_addr, bus_byteen,
//   bus_wdata           : bus request (all zero outside REQ)
//   bus_ack, bus_rdata  : bus completion and read word
module dm_bridge
    import dm_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m_valid,
    input  logic [NBYTES-1:0] byteen,
    input  logic [LDW-1:0]    ld_op,
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   wdata,
    output logic              stall,
    output logic [XLEN-1:0]   rd_data,
    output logic              rd_valid,
    output logic              err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [XLEN-1:0]   bus_addr,
    output logic [NBYTES-1:0] bus_byteen,
    output logic [XLEN-1:0]   bus_wdata,
    input  logic              bus_ack,
    input  logic [XLEN-1:0]   bus_rdata
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    state_e          state;
    req_t            cap;
    req_t            cap_next;
    logic [CW-1:0]   cnt;
    logic            err_q;
    logic [XLEN-1:0] rd_q;
    logic            rd_valid_q;
    logic            accept;
    logic            in_req;
    logic            is_store;
    logic            cap_is_load;
    logic            timeout_hit;
    logic [XLEN-1:0] ext_data;

    // A store wins over a load when both are flagged
    assign is_store    = (byteen != '0);
    assign accept      = m_valid && (is_store || (ld_op != LD_NONE));
    assign in_req      = (state == ST_REQ);
    assign cap_is_load = (cap.ld_op != LD_NONE);
    assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

    // Request payload as it will be registered on acceptance
    always_comb begin
        cap_next        = '0;
        cap_next.addr   = addr;
        cap_next.we     = is_store;
        cap_next.byteen = is_store ? byteen : '1;
        cap_next.ld_op  = is_store ? LD_NONE : ld_op;
        cap_next.wdata  = is_store ? replicate_wdata(byteen, wdata) : '0;
    end

    ld_ext u_ld_ext (
        .word    (bus_rdata),
        .addr_lo (cap.addr[1:0]),
        .ld_op   (cap.ld_op),
        .rd_data (ext_data)
    );

    // Control FSM and all bridge state
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cap        <= '0;
            cnt        <= '0;
            err_q      <= 1'b0;
            rd_q       <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cap   <= cap_next;
                        cnt   <= '0;
                        state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus_ack) begin
                        rd_q       <= ext_data;
                        rd_valid_q <= cap_is_load;
                        state      <= ST_DONE;
                    end else if (timeout_hit) begin
                        // Abort: flag the error and retire with a zero result
                        err_q      <= 1'b1;
                        rd_q       <= '0;
                        rd_valid_q <= cap_is_load;
                        state      <= ST_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    // Instruction still presented here is the one retiring
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Stall covers the accepting IDLE cycle plus every REQ cycle
    assign stall      = in_req || ((state == ST_IDLE) && accept && !reset);

    assign bus_req    = in_req;
    assign bus_we     = in_req && cap.we;
    assign bus_addr   = in_req ? {cap.addr[XLEN-1:2], 2'b00} : '0;
    assign bus_byteen = in_req ? cap.byteen : '0;
    assign bus_wdata  = in_req ? cap.wdata : '0;

    assign rd_data    = rd_q;
    assign rd_valid   = rd_valid_q;
    assign err        = err_q;

endmodule

// File: tb/tb_dm_bridge.sv
// Self-checking bench for dm_bridge: directed scenarios plus randomized
// back-to-back loads/stores against a behavioural model of the bridge.
module tb_dm_bridge;

    localparam int unsigned TO = 255;

    logic        clk;
    logic        reset;
    logic        m_valid;
    logic [3:0]  byteen;
    logic [2:0]  ld_op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_byteen;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int checks   = 0;
    int failures = 0;
    logic exp_err = 1'b0;

    dm_bridge #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .m_valid    (m_valid),
        .byteen     (byteen),
        .ld_op      (ld_op),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .err        (err),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_byteen (bus_byteen),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Store data as it should appear on the bus: narrow data copied to all lanes
    function automatic logic [31:0] model_rep(input logic [3:0] be, input logic [31:0] d);
        int n = 0;
        for (int i = 0; i < 4; i++) if (be[i]) n++;
        if (n == 1) return (d & 32'hFF) * 32'h01010101;
        if (n == 2) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    // Load result computed arithmetically from the word and byte offset
    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] w);
        logic [31:0] b, h;
        int unsigned off;
        off = a % 4;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (op)
            3'd1: return w;
            3'd2: return (b >= 128) ? b + 32'hFFFFFF00 : b;
            3'd3: return b;
            3'd4: return (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'd5: return h;
            default: return 32'h0;
        endcase
    endfunction

    // Runs one instruction through accept / REQ / DONE and checks every cycle.
    // ack_at: REQ cycle (1-based) on which bus_ack is given; 0 = never.
    task automatic run_txn(input string tag, input logic [3:0] be, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rdat, input int ack_at);
        logic        st;
        logic [3:0]  e_be;
        logic [31:0] e_rd;
        int          req_cycles;
        int          stalls;
        st         = (be != 4'h0);
        e_be       = st ? be : 4'hF;
        req_cycles = (ack_at == 0) ? int'(TO) : ack_at;
        e_rd       = (ack_at == 0) ? 32'h0 : model_load(op, a, rdat);
        stalls     = 0;

        // accept cycle
        @(negedge clk);
        m_valid = 1'b1; byteen = be; ld_op = op; addr = a; wdata = wd;
        bus_ack = 1'b0; bus_rdata = rdat;
        #1;
        if (stall) stalls++;
        checks++;
        if (bus_req !== 1'b0 || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s idle: bus_req=%b rd_valid=%b required 0/0", tag, bus_req, rd_valid);
        end

        for (int k = 1; k <= req_cycles; k++) begin
            @(negedge clk);
            bus_ack = (k == ack_at);
            #1;
            if (stall) stalls++;
            checks++;
            if (bus_req !== 1'b1 || bus_addr !== (a & 32'hFFFFFFFC) ||
                bus_byteen !== e_be || bus_we !== st) begin
                failures++;
                $display("FAIL %s req%0d: req=%b addr=%h be=%b we=%b required 1/%h/%b/%b",
                         tag, k, bus_req, bus_addr, bus_byteen, bus_we,
                         a & 32'hFFFFFFFC, e_be, st);
            end
            if (st) begin
                checks++;
                if (bus_wdata !== model_rep(be, wd)) begin
                    failures++;
                    $display("FAIL %s wdata: got %h required %h", tag, bus_wdata, model_rep(be, wd));
                end
            end
        end
        if (ack_at == 0) exp_err = 1'b1;

        // DONE cycle: same instruction still presented, must be ignored
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        if (stall) stalls++;
        checks++;
        if (stall !== 1'b0 || bus_req !== 1'b0 || rd_valid !== !st || err !== exp_err) begin
            failures++;
            $display("FAIL %s done: stall=%b req=%b rd_valid=%b err=%b required 0/0/%b/%b",
                     tag, stall, bus_req, rd_valid, err, !st, exp_err);
        end
        if (!st) begin
            checks++;
            if (rd_data !== e_rd) begin
                failures++;
                $display("FAIL %s rd_data: got %h required %h", tag, rd_data, e_rd);
            end
        end
        checks++;
        if (stalls != req_cycles + 1) begin
            failures++;
            $display("FAIL %s stall_count: got %0d required %0d", tag, stalls, req_cycles + 1);
        end
        m_valid = 1'b0; byteen = 4'h0; ld_op = 3'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        m_valid = 1'b1; byteen = 4'hF; ld_op = 3'd0; addr = 32'h100; wdata = 32'hFFFFFFFF;
        bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({stall, rd_valid, err, bus_req, bus_we} !== 5'b0 || rd_data !== 32'h0 ||
            bus_addr !== 32'h0 || bus_byteen !== 4'h0 || bus_wdata !== 32'h0) begin
            failures++;
            $display("FAIL reset: stall=%b rdv=%b err=%b req=%b rd=%h addr=%h required all 0",
                     stall, rd_valid, err, bus_req, rd_data, bus_addr);
        end
        m_valid = 1'b0; byteen = 4'h0; bus_ack = 1'b0;
        reset = 1'b0;
        exp_err = 1'b0;
    endtask

    task automatic test_store_word();
        run_txn("sw", 4'b1111, 3'd0, 32'h104, 32'h12345678, 32'h0, 1);
    endtask

    task automatic test_store_byte();
        run_txn("sb", 4'b1000, 3'd0, 32'h7, 32'h000000AB, 32'h0, 1);
    endtask

    task automatic test_load_byte();
        run_txn("lb", 4'b0000, 3'd2, 32'h3, 32'h0, 32'h80FF0011, 3);
    endtask

    task automatic test_load_half();
        run_txn("lhu", 4'b0000, 3'd5, 32'h2, 32'h0, 32'h9ABC1234, 1);
        run_txn("lh", 4'b0000, 3'd4, 32'h0, 32'h0, 32'h0000F00D, 2);
    endtask

    task automatic test_noop();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            m_valid = 1'b1; byteen = 4'h0; ld_op = 3'd0; bus_ack = (i == 2);
            #1;
            checks++;
            if (stall !== 1'b0 || bus_req !== 1'b0 || rd_valid !== 1'b0) begin
                failures++;
                $display("FAIL noop%0d: stall=%b req=%b rdv=%b required 0", i, stall, bus_req, rd_valid);
            end
        end
        m_valid = 1'b0; bus_ack = 1'b0;
    endtask

    task automatic test_store_priority();
        run_txn("sh_with_ldop", 4'b1100, 3'd1, 32'h20, 32'hCAFE5A5A, 32'hDEADBEEF, 2);
    endtask

    task automatic test_back_to_back();
        logic [3:0]  be;
        logic [2:0]  op;
        logic [31:0] a;
        int          sz;
        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            if ($urandom_range(1, 0) == 1) begin
                sz = $urandom_range(2, 0);
                if (sz == 0)      be = 4'b0001 << (a % 4);
                else if (sz == 1) be = (a % 4 >= 2) ? 4'b1100 : 4'b0011;
                else              be = 4'b1111;
                op = 3'($urandom_range(5, 0));
            end else begin
                be = 4'b0000;
                op = 3'($urandom_range(5, 1));
            end
            run_txn("rand", be, op, a, $urandom, $urandom, $urandom_range(6, 1));
        end
    endtask

    task automatic test_timeout();
        run_txn("timeout", 4'b0000, 3'd1, 32'h40, 32'h0, 32'h55AA55AA, 0);
        // err must stay set across a later good transaction
        run_txn("after_to", 4'b0000, 3'd3, 32'h41, 32'h0, 32'h0000F700, 1);
    endtask

    task automatic test_reset_mid_req();
        @(negedge clk);
        m_valid = 1'b1; byteen = 4'h0; ld_op = 3'd1; addr = 32'h80; bus_ack = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (bus_req !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid pre: bus_req=%b required 1", bus_req);
        end
        reset = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (bus_req !== 1'b0 || stall !== 1'b0 || err !== 1'b0 || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid: req=%b stall=%b err=%b rdv=%b required 0", bus_req, stall, err, rd_valid);
        end
        m_valid = 1'b0; ld_op = 3'd0;
        reset = 1'b0;
        exp_err = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (bus_req !== 1'b0 || stall !== 1'b0) begin
                failures++;
                $display("FAIL rst_noretry%0d: req=%b stall=%b required 0", i, bus_req, stall);
            end
        end
        run_txn("post_rst", 4'b0000, 3'd4, 32'h6, 32'h0, 32'h8001FFFF, 1);
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_store_byte();
        test_load_byte();
        test_load_half();
        test_noop();
        test_store_priority();
        test_back_to_back();
        test_timeout();
        test_reset_mid_req();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dm_bridge.md
DM_BRIDGE -- requirements
Module: dm_bridge

Interface
REQ-001 Parameter TIMEOUT, default 255, is the max cycles to wait for bus_ack before abort.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 m_valid  input  1  M-stage holds a memory instruction this cycle.
REQ-005 byteen  input  4  store byte enables from the byte-enable stage; 0000 = not a store.
REQ-006 ld_op  input  3  load type: 000 none, 001 lw, 010 lb, 011 lbu, 100 lh, 101 lhu.
REQ-007 addr  input  32  byte address.
REQ-008 wdata  input  32  unshifted store source register value.
REQ-009 stall  output  1  freezes pipeline stages up to and including M.
REQ-010 rd_data  output  32  aligned, extended load result.
REQ-011 rd_valid  output  1  rd_data valid; one cycle per completed load.
REQ-012 err  output  1  sticky timeout flag.
REQ-013 bus_req, bus_we  output  1 each  request / write strobe.
REQ-014 bus_addr  output  32  {addr[31:2],2'b00}.
REQ-015 bus_byteen  output  4  lane enables; 1111 for loads.
REQ-016 bus_wdata  output  32  lane-replicated store data.
REQ-017 bus_ack  input  1  bus completes the request this cycle.
REQ-018 bus_rdata  input  32  read word, valid with bus_ack.

Function
REQ-019 FSM states: IDLE, REQ, DONE.
REQ-020 IDLE: m_valid with byteen!=0 or ld_op!=0 captures addr, byteen, ld_op, replicated wdata into registers and moves to REQ; otherwise remains IDLE.
REQ-021 byteen!=0 with ld_op!=0 is treated as a store; ld_op ignored.
REQ-022 m_valid with byteen==0 and ld_op==000 is a no-op; no stall.
REQ-023 stall = (IDLE and accepting) or REQ; stall low in DONE.
REQ-024 bus_req and all bus_* outputs driven from captured registers, high for every REQ cycle, low otherwise.
REQ-025 Store replication by byteen popcount: 1 -> {4{wdata[7:0]}}, 2 -> {2{wdata[15:0]}}, 4 -> wdata.
REQ-026 REQ with bus_ack -> DONE; load captures bus_rdata on that edge.
REQ-027 REQ cycle counter starts at 0 on entry; reaching TIMEOUT without ack sets err, forces rd_data 0, goes to DONE.
REQ-028 DONE lasts exactly one cycle, then IDLE; m_valid in DONE ignored (same instruction retiring).
REQ-029 rd_data: lb/lbu select byte addr[1:0], lh/lhu select half addr[1], sign/zero extend; lw whole word.
REQ-030 rd_valid high in DONE for loads only.
REQ-031 bus_ack outside REQ ignored.
REQ-032 Minimum latency: accept at cycle T, bus_req T+1, ack T+1, DONE T+2; 2 stall cycles.

Reset
REQ-033 reset forces IDLE, counter 0, err 0, captured registers 0, on that edge.
REQ-034 All outputs 0 while in reset, including mid-REQ; bus_req drops the cycle after reset asserted, no retry.

Structure
REQ-035 Shared package holds FSM state encoding, ld_op codes, TIMEOUT default.
REQ-036 Combinational load extender is sub-module ld_ext (word, addr[1:0], ld_op -> rd_data).

Verification
REQ-037 sw addr 0x104 wdata 0x12345678, ack in 1st REQ cycle -> bus_addr 0x104, byteen 1111, we 1, stall 2 cycles.
REQ-038 sb addr 0x7, byteen 1000, wdata 0xAB -> bus_wdata 0xABABABAB, bus_byteen 1000.
REQ-039 lb addr 0x3, bus_rdata 0x80FF0011, ack after 3 cycles -> rd_data 0xFFFFFF80, rd_valid 1 cycle, stall 4 cycles.
REQ-040 lhu addr 0x2, bus_rdata 0x9ABC1234 -> rd_data 0x00009ABC.
REQ-041 Load, no ack for TIMEOUT cycles -> err 1 sticky, rd_data 0, IDLE next.
REQ-042 reset asserted during REQ -> bus_req 0, stall 0 next cycle, err 0.
